// File: rtl/axi_spsram_memory.sv
// AXI slave wrapped around a single-port, byte-writable SRAM array.
// One transaction at a time; round-robin between AW and AR when both request.
module axi_spsram_memory #(
  parameter int                 BW_ADDR    = 32,
  parameter int                 BW_DATA    = 128,
  parameter int                 BW_AXI_TID = 16,
  parameter logic [BW_ADDR-1:0] BASEADDR   = '0,
  parameter int                 MEM_SIZE   = 131072
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    enable,
  input  logic [BW_AXI_TID-1:0]   rxawid,
  input  logic [BW_ADDR-1:0]      rxawaddr,
  input  logic [3:0]              rxawlen,
  input  logic [2:0]              rxawsize,
  input  logic [1:0]              rxawburst,
  input  logic                    rxawvalid,
  output logic                    rxawready,
  input  logic [BW_AXI_TID-1:0]   rxwid,
  input  logic [BW_DATA-1:0]      rxwdata,
  input  logic [BW_DATA/8-1:0]    rxwstrb,
  input  logic                    rxwlast,
  input  logic                    rxwvalid,
  output logic                    rxwready,
  output logic [BW_AXI_TID-1:0]   rxbid,
  output logic [1:0]              rxbresp,
  output logic                    rxbvalid,
  input  logic                    rxbready,
  input  logic [BW_AXI_TID-1:0]   rxarid,
  input  logic [BW_ADDR-1:0]      rxaraddr,
  input  logic [3:0]              rxarlen,
  input  logic [2:0]              rxarsize,
  input  logic [1:0]              rxarburst,
  input  logic                    rxarvalid,
  output logic                    rxarready,
  output logic [BW_AXI_TID-1:0]   rxrid,
  output logic [BW_DATA-1:0]      rxrdata,
  output logic [1:0]              rxrresp,
  output logic                    rxrlast,
  output logic                    rxrvalid,
  input  logic                    rxrready
);
  localparam int BYTES    = BW_DATA / 8;
  localparam int DEPTH    = MEM_SIZE / BYTES;
  localparam int BW_INDEX = $clog2(DEPTH);
  localparam int LOG2B    = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RISSUE, S_RDATA} state_t;

  state_t                r_state, w_next_state;
  logic [BW_AXI_TID-1:0] r_id;
  logic [BW_ADDR-1:0]    r_addr;
  logic [3:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err, r_last_rd, r_rlast;
  logic [1:0]            r_rresp;
  logic [BW_DATA-1:0]    r_rdata;
  logic [BW_DATA-1:0]    r_mem [DEPTH];

  logic [BW_ADDR-1:0]    w_offset, w_step, w_wrap_mask, w_next_addr;
  logic [BW_INDEX-1:0]   w_index;
  logic                  w_oor, w_wrap_ok, w_last_beat;
  logic                  w_aw_req, w_ar_req, w_grant_aw, w_grant_ar;
  logic                  w_w_hs, w_r_hs, w_rd_issue;
  logic                  w_unused;

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > 3'(LOG2B)) ? 3'(LOG2B) : s;
  endfunction

  assign w_unused = ^{rxwid, rxwlast};

  // Address map and burst address generation; underflow wraps to a huge offset
  assign w_offset    = r_addr - BASEADDR;
  assign w_oor       = (w_offset >= BW_ADDR'(MEM_SIZE));
  assign w_index     = w_offset[LOG2B +: BW_INDEX];
  assign w_step      = BW_ADDR'(1) << r_size;
  assign w_wrap_ok   = (r_burst == 2'b10) &&
                       (r_len == 4'd1 || r_len == 4'd3 || r_len == 4'd7 || r_len == 4'd15);
  assign w_wrap_mask = ((BW_ADDR'(r_len) + BW_ADDR'(1)) << r_size) - BW_ADDR'(1);
  assign w_last_beat = (r_cnt == r_len);

  always_comb begin
    w_next_addr = r_addr + w_step;
    if (r_burst == 2'b00)
      w_next_addr = r_addr;
    else if (w_wrap_ok)
      w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
  end

  assign w_aw_req   = enable && rxawvalid && !rstnn && (r_state == S_IDLE);
  assign w_ar_req   = enable && rxarvalid && !rstnn && (r_state == S_IDLE);
  assign w_grant_aw = w_aw_req && (!w_ar_req || r_last_rd);
  assign w_grant_ar = w_ar_req && !w_grant_aw;
  assign w_w_hs     = (r_state == S_WDATA) && rxwvalid;
  assign w_r_hs     = (r_state == S_RDATA) && rxrready;
  assign w_rd_issue = (r_state == S_RISSUE) || (w_r_hs && !r_rlast);

  always_ff @(posedge clk) begin
    if (rstnn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_aw) w_next_state = S_WDATA;
                else if (w_grant_ar) w_next_state = S_RISSUE;
      S_WDATA:  if (w_w_hs && w_last_beat) w_next_state = S_WRESP;
      S_WRESP:  if (rxbready) w_next_state = S_IDLE;
      S_RISSUE: w_next_state = S_RDATA;
      S_RDATA:  if (w_r_hs && r_rlast) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rxawready = w_grant_aw;
    rxarready = w_grant_ar;
    rxwready  = (r_state == S_WDATA);
    rxbvalid  = (r_state == S_WRESP);
    rxrvalid  = (r_state == S_RDATA);
  end

  always_ff @(posedge clk) begin
    if (rstnn) begin
      r_id      <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_last_rd <= 1'b1;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
    end else begin
      if (w_grant_aw || w_grant_ar) begin
        r_id      <= w_grant_aw ? rxawid : rxarid;
        r_cnt     <= '0;
        r_err     <= 1'b0;
        r_last_rd <= w_grant_ar;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_oor) r_err <= 1'b1;
      end
      if (w_rd_issue) begin
        r_cnt   <= r_cnt + 4'd1;
        r_rlast <= w_last_beat;
        r_rresp <= w_oor ? 2'b10 : 2'b00;
      end else if (w_r_hs && r_rlast) begin
        r_rlast <= 1'b0;
      end
    end
  end

  // Burst parameters: latched on grant, address advanced per beat
  always_ff @(posedge clk) begin
    if (w_grant_aw) begin
      r_addr  <= rxawaddr;
      r_len   <= rxawlen;
      r_size  <= clamp_size(rxawsize);
      r_burst <= rxawburst;
    end else if (w_grant_ar) begin
      r_addr  <= rxaraddr;
      r_len   <= rxarlen;
      r_size  <= clamp_size(rxarsize);
      r_burst <= rxarburst;
    end else if (w_w_hs || w_rd_issue) begin
      r_addr  <= w_next_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_hs && !w_oor) begin
      for (int k = 0; k < BYTES; k++)
        if (rxwstrb[k]) r_mem[w_index][8*k +: 8] <= rxwdata[8*k +: 8];
    end
  end

  // Read register only changes on an issued read, so data holds under backpressure
  always_ff @(posedge clk) begin
    if (rstnn)           r_rdata <= '0;
    else if (w_rd_issue) r_rdata <= w_oor ? '0 : r_mem[w_index];
  end

  assign rxbid   = r_id;
  assign rxbresp = {r_err, 1'b0};
  assign rxrid   = r_id;
  assign rxrdata = r_rdata;
  assign rxrresp = r_rresp;
  assign rxrlast = r_rlast;
endmodule

// File: tb/tb_axi_spsram_memory.sv
// Directed bench for axi_spsram_memory: queued expected responses are popped
// and compared as the B and R channels deliver them.
module tb_axi_spsram_memory;
  logic         clk = 1'b0;
  logic         rstnn, enable;
  logic [15:0]  rxawid, rxwid, rxbid, rxarid, rxrid;
  logic [31:0]  rxawaddr, rxaraddr;
  logic [3:0]   rxawlen, rxarlen;
  logic [2:0]   rxawsize, rxarsize;
  logic [1:0]   rxawburst, rxarburst, rxbresp, rxrresp;
  logic         rxawvalid, rxawready, rxwlast, rxwvalid, rxwready;
  logic         rxbvalid, rxbready, rxarvalid, rxarready;
  logic         rxrlast, rxrvalid, rxrready;
  logic [127:0] rxwdata, rxrdata;
  logic [15:0]  rxwstrb;

  typedef struct { logic [15:0] id; logic [127:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [15:0] id; logic [1:0] resp; } bexp_t;
  rexp_t        rq[$];
  bexp_t        bq[$];
  logic [127:0] mdl [int];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int t_aw, t_w, t_b, t_ar, t_r0;
  bit chk_blocked = 1'b0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] WA = 128'hAAAA0000111122223333444455556666;
  localparam logic [127:0] WB = 128'hBBBB0000777788889999AAAABBBBCCCC;
  localparam logic [127:0] WC = 128'hCCCC0000DDDDEEEEFFFF000011112222;
  localparam logic [127:0] WD = 128'hDDDD0000333344445555666677778888;

  axi_spsram_memory dut (
    .clk(clk), .rstnn(rstnn), .enable(enable),
    .rxawid(rxawid), .rxawaddr(rxawaddr), .rxawlen(rxawlen), .rxawsize(rxawsize),
    .rxawburst(rxawburst), .rxawvalid(rxawvalid), .rxawready(rxawready),
    .rxwid(rxwid), .rxwdata(rxwdata), .rxwstrb(rxwstrb), .rxwlast(rxwlast),
    .rxwvalid(rxwvalid), .rxwready(rxwready),
    .rxbid(rxbid), .rxbresp(rxbresp), .rxbvalid(rxbvalid), .rxbready(rxbready),
    .rxarid(rxarid), .rxaraddr(rxaraddr), .rxarlen(rxarlen), .rxarsize(rxarsize),
    .rxarburst(rxarburst), .rxarvalid(rxarvalid), .rxarready(rxarready),
    .rxrid(rxrid), .rxrdata(rxrdata), .rxrresp(rxrresp), .rxrlast(rxrlast),
    .rxrvalid(rxrvalid), .rxrready(rxrready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_wr(input logic [31:0] addr, input logic [127:0] d,
                                   input logic [15:0] s);
    logic [127:0] w;
    int idx;
    if (addr >= 32'h20000) return;
    idx = int'(addr >> 4);
    w = mdl.exists(idx) ? mdl[idx] : '0;
    for (int k = 0; k < 16; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
    mdl[idx] = w;
  endfunction

  function automatic void push_r(input logic [15:0] id, input logic [31:0] addr, input logic last);
    rq.push_back('{id, mdl[int'(addr >> 4)], 2'b00, last});
  endfunction

  // All tasks start and end 1 time unit after a rising edge; sampling is at +2.
  task automatic aw_send(input logic [15:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    rxawid = id; rxawaddr = a; rxawlen = len; rxawsize = sz; rxawburst = bu; rxawvalid = 1'b1;
    #1;
    while (!rxawready && n < 20) begin @(posedge clk); #2; n++; end
    chk1("aw_ready", rxawready, 1'b1);
    t_aw = cyc;
    @(posedge clk); #1; rxawvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [15:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    rxarid = id; rxaraddr = a; rxarlen = len; rxarsize = sz; rxarburst = bu; rxarvalid = 1'b1;
    #1;
    while (!rxarready && n < 20) begin @(posedge clk); #2; n++; end
    chk1("ar_ready", rxarready, 1'b1);
    t_ar = cyc;
    @(posedge clk); #1; rxarvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [127:0] d, input logic [15:0] s);
    int n = 0;
    rxwdata = d; rxwstrb = s; rxwvalid = 1'b1;
    #1;
    while (!rxwready && n < 20) begin @(posedge clk); #2; n++; end
    chk1("w_ready", rxwready, 1'b1);
    t_w = cyc;
    @(posedge clk); #1; rxwvalid = 1'b0;
  endtask

  task automatic b_recv();
    bexp_t e;
    int n = 0;
    rxbready = 1'b1;
    #1;
    while (!rxbvalid && n < 20) begin @(posedge clk); #2; n++; end
    chk1("b_valid", rxbvalid, 1'b1);
    t_b = cyc;
    e = bq.pop_front();
    chkw("b_id", {112'd0, rxbid}, {112'd0, e.id});
    chkw("b_resp", {126'd0, rxbresp}, {126'd0, e.resp});
    @(posedge clk); #1; rxbready = 1'b0;
  endtask

  task automatic r_recv(input int nbeats, input int stall_beat, input int stall_n);
    rexp_t e;
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      rxrready = (b != stall_beat);
      #1;
      while (!rxrvalid && n < 20) begin @(posedge clk); #2; n++; end
      chk1("r_valid", rxrvalid, 1'b1);
      if (b == 0) t_r0 = cyc;
      e = rq.pop_front();
      chkw("r_id", {112'd0, rxrid}, {112'd0, e.id});
      chkw("r_data", rxrdata, e.data);
      chkw("r_resp", {126'd0, rxrresp}, {126'd0, e.resp});
      chk1("r_last", rxrlast, e.last);
      if (chk_blocked) begin
        chk1("awready_blocked", rxawready, 1'b0);
        chk1("arready_blocked", rxarready, 1'b0);
      end
      if (b == stall_beat) begin
        repeat (stall_n) begin
          @(posedge clk); #2;
          chk1("stall_valid", rxrvalid, 1'b1);
          chkw("stall_data", rxrdata, e.data);
        end
        rxrready = 1'b1;
      end
      @(posedge clk); #1;
    end
    rxrready = 1'b0;
  endtask

  initial begin
    rstnn = 1'b1; enable = 1'b1;
    rxawid = '0; rxawaddr = '0; rxawlen = '0; rxawsize = '0; rxawburst = '0; rxawvalid = 1'b1;
    rxarid = '0; rxaraddr = '0; rxarlen = '0; rxarsize = '0; rxarburst = '0; rxarvalid = 1'b1;
    rxwid = '0; rxwdata = '0; rxwstrb = '0; rxwlast = 1'b0; rxwvalid = 1'b0;
    rxbready = 1'b0; rxrready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk1("rst_awready", rxawready, 1'b0);
    chk1("rst_arready", rxarready, 1'b0);
    chk1("rst_wready", rxwready, 1'b0);
    chk1("rst_bvalid", rxbvalid, 1'b0);
    chk1("rst_rvalid", rxrvalid, 1'b0);
    chk1("rst_rlast", rxrlast, 1'b0);
    chkw("rst_ids", {96'd0, rxbid, rxrid}, 128'd0);
    chkw("rst_resps", {124'd0, rxbresp, rxrresp}, 128'd0);
    chkw("rst_rdata", rxrdata, 128'd0);
    rxawvalid = 1'b0; rxarvalid = 1'b0; rstnn = 1'b0;
    @(posedge clk); #1;

    // Single-beat write then read with latency checks
    aw_send(16'h5, 32'h10, 4'd0, 3'd4, 2'b01);
    w_beat(D1, 16'hFFFF); model_wr(32'h10, D1, 16'hFFFF);
    chki("aw_to_wready", t_w - t_aw, 1);
    bq.push_back('{16'h5, 2'b00});
    b_recv();
    chki("wlast_to_bvalid", t_b - t_w, 1);
    ar_send(16'h9, 32'h10, 4'd0, 3'd4, 2'b01);
    rq.push_back('{16'h9, D1, 2'b00, 1'b1});
    r_recv(1, -1, 0);
    chki("ar_to_rvalid", t_r0 - t_ar, 2);

    // Byte strobe merge
    aw_send(16'h1, 32'h40, 4'd0, 3'd4, 2'b01);
    w_beat({128{1'b1}}, 16'hFFFF); model_wr(32'h40, {128{1'b1}}, 16'hFFFF);
    bq.push_back('{16'h1, 2'b00}); b_recv();
    aw_send(16'h2, 32'h40, 4'd0, 3'd4, 2'b01);
    w_beat(128'hAB, 16'h0001); model_wr(32'h40, 128'hAB, 16'h0001);
    bq.push_back('{16'h2, 2'b00}); b_recv();
    ar_send(16'h3, 32'h40, 4'd0, 3'd4, 2'b01);
    rq.push_back('{16'h3, {{120{1'b1}}, 8'hAB}, 2'b00, 1'b1});
    r_recv(1, -1, 0);

    // INCR burst with read backpressure on beat 1
    aw_send(16'h4, 32'h100, 4'd3, 3'd4, 2'b01);
    w_beat(WA, 16'hFFFF); model_wr(32'h100, WA, 16'hFFFF);
    w_beat(WB, 16'hFFFF); model_wr(32'h110, WB, 16'hFFFF);
    w_beat(WC, 16'hFFFF); model_wr(32'h120, WC, 16'hFFFF);
    w_beat(WD, 16'hFFFF); model_wr(32'h130, WD, 16'hFFFF);
    bq.push_back('{16'h4, 2'b00}); b_recv();
    ar_send(16'h6, 32'h100, 4'd3, 3'd4, 2'b01);
    rq.push_back('{16'h6, WA, 2'b00, 1'b0});
    rq.push_back('{16'h6, WB, 2'b00, 1'b0});
    rq.push_back('{16'h6, WC, 2'b00, 1'b0});
    rq.push_back('{16'h6, WD, 2'b00, 1'b1});
    r_recv(4, 1, 2);

    // WRAP read and FIXED write
    ar_send(16'hC, 32'h130, 4'd3, 3'd4, 2'b10);
    rq.push_back('{16'hC, WD, 2'b00, 1'b0});
    rq.push_back('{16'hC, WA, 2'b00, 1'b0});
    rq.push_back('{16'hC, WB, 2'b00, 1'b0});
    rq.push_back('{16'hC, WC, 2'b00, 1'b1});
    r_recv(4, -1, 0);
    aw_send(16'hD, 32'h200, 4'd2, 3'd4, 2'b00);
    w_beat(WA, 16'hFFFF); w_beat(WB, 16'hFFFF); w_beat(WC, 16'hFFFF);
    model_wr(32'h200, WC, 16'hFFFF);
    bq.push_back('{16'hD, 2'b00}); b_recv();
    ar_send(16'hE, 32'h200, 4'd0, 3'd4, 2'b01);
    rq.push_back('{16'hE, WC, 2'b00, 1'b1});
    r_recv(1, -1, 0);

    // Out-of-range write/read; word 0 shares low index bits with 0x20000
    aw_send(16'h11, 32'h0, 4'd0, 3'd4, 2'b01);
    w_beat(WB, 16'hFFFF); model_wr(32'h0, WB, 16'hFFFF);
    bq.push_back('{16'h11, 2'b00}); b_recv();
    aw_send(16'h12, 32'h20000, 4'd0, 3'd4, 2'b01);
    w_beat(WD, 16'hFFFF); model_wr(32'h20000, WD, 16'hFFFF);
    bq.push_back('{16'h12, 2'b10}); b_recv();
    ar_send(16'h13, 32'h0, 4'd0, 3'd4, 2'b01);
    rq.push_back('{16'h13, WB, 2'b00, 1'b1});
    r_recv(1, -1, 0);
    ar_send(16'h14, 32'h20000, 4'd0, 3'd4, 2'b01);
    rq.push_back('{16'h14, 128'd0, 2'b10, 1'b1});
    r_recv(1, -1, 0);

    // Arbitration from a fresh reset
    rstnn = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    rstnn = 1'b0;
    rxawid = 16'h7; rxawaddr = 32'h300; rxawlen = 4'd0; rxawsize = 3'd4; rxawburst = 2'b01;
    rxarid = 16'h8; rxaraddr = 32'h10;  rxarlen = 4'd0; rxarsize = 3'd4; rxarburst = 2'b01;
    rxawvalid = 1'b1; rxarvalid = 1'b1;
    #1;
    chk1("arb1_awready", rxawready, 1'b1);
    chk1("arb1_arready", rxarready, 1'b0);
    @(posedge clk); #1; rxawvalid = 1'b0;
    w_beat(WA, 16'hFFFF); model_wr(32'h300, WA, 16'hFFFF);
    #1;
    chk1("arready_in_wresp", rxarready, 1'b0);
    @(posedge clk); #1;
    bq.push_back('{16'h7, 2'b00}); b_recv();
    rxawid = 16'hA; rxawaddr = 32'h310; rxawvalid = 1'b1;
    #1;
    chk1("arb2_arready", rxarready, 1'b1);
    chk1("arb2_awready", rxawready, 1'b0);
    @(posedge clk); #1; rxarvalid = 1'b0;
    push_r(16'h8, 32'h10, 1'b1);
    r_recv(1, -1, 0);
    #1;
    chk1("arb3_awready", rxawready, 1'b1);
    @(posedge clk); #1; rxawvalid = 1'b0;
    w_beat(WB, 16'hFFFF); model_wr(32'h310, WB, 16'hFFFF);
    bq.push_back('{16'hA, 2'b00}); b_recv();

    // enable=0 blocks new requests while an accepted read drains
    ar_send(16'hB, 32'h100, 4'd3, 3'd4, 2'b01);
    enable = 1'b0;
    rxawvalid = 1'b1; rxarvalid = 1'b1;
    push_r(16'hB, 32'h100, 1'b0); push_r(16'hB, 32'h110, 1'b0);
    push_r(16'hB, 32'h120, 1'b0); push_r(16'hB, 32'h130, 1'b1);
    chk_blocked = 1'b1;
    r_recv(4, -1, 0);
    chk_blocked = 1'b0;
    #1;
    chk1("dis_awready_idle", rxawready, 1'b0);
    chk1("dis_arready_idle", rxarready, 1'b0);
    @(posedge clk); #2;
    chk1("dis_awready_idle2", rxawready, 1'b0);
    chk1("dis_arready_idle2", rxarready, 1'b0);
    rxawvalid = 1'b0; rxarvalid = 1'b0; enable = 1'b1;
    @(posedge clk); #1;

    // Array contents survive reset
    ar_send(16'hF, 32'h10, 4'd0, 3'd4, 2'b01);
    push_r(16'hF, 32'h10, 1'b1);
    r_recv(1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
